// File: rtl/ps2_keyboard_pkg.sv
// Register map, status bit layout and receiver state type shared by the PS/2 keyboard port.
package ps2_pkg;

  localparam logic [3:0] PS2_DATA_OFF = 4'h0;
  localparam logic [3:0] PS2_STAT_OFF = 4'h4;

  localparam int ST_READY   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_PERR    = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // Frame layout is {stop, parity, data[7:0]}; odd parity over data+parity and a high stop bit.
  function automatic logic frameValid(input logic [9:0] frame);
    return (^frame[8:0]) && frame[9];
  endfunction

endpackage

// File: rtl/ps2_keyboard_fifo.sv
// Synchronous scan-code queue; a pop frees a slot for a same-cycle push even when full.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (PW+1)'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// Memory-mapped PS/2 keyboard receiver: samples the keyboard lines, deframes 11-bit
// frames and queues valid scan codes for CPU reads at DATA/STATUS offsets.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic [3:0]  rd_addr,
  output logic [31:0] keymemout
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]      r_clkSync;
  logic [1:0]      r_dataSync;
  logic            r_clkPrev;
  logic            w_fall;
  logic            w_dataS;

  rx_state_t       r_state;
  logic [3:0]      r_bitCnt;
  logic [9:0]      r_shift;
  logic [7:0]      r_pushByte;
  logic            r_push;
  logic            r_perrSet;
  logic [TO_W-1:0] r_toCnt;
  logic            w_timeout;

  logic            r_ovf;
  logic            r_perr;
  logic            w_ovfSet;

  logic            w_dataRd;
  logic            w_statRd;
  logic            w_pop;
  logic [7:0]      w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [31:0]     w_status;

  // Synchronizers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  assign w_fall    = r_clkPrev & ~r_clkSync[1];
  assign w_dataS   = r_dataSync[1];
  assign w_timeout = (r_toCnt == TO_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_toCnt <= '0;
    end else if (w_fall) begin
      r_toCnt <= '0;
    end else if (!w_timeout) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_pushByte <= '0;
      r_push     <= 1'b0;
      r_perrSet  <= 1'b0;
    end else begin
      r_push    <= 1'b0;
      r_perrSet <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall && !w_dataS) begin
            r_state  <= SHIFT;
            r_bitCnt <= '0;
            r_shift  <= '0;
          end
        end
        SHIFT: begin
          if (w_fall) begin
            r_shift  <= {w_dataS, r_shift[9:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 4'd9) begin
              r_state <= CHECK;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
          end
        end
        CHECK: begin
          r_pushByte <= r_shift[7:0];
          r_push     <= frameValid(r_shift);
          r_perrSet  <= !frameValid(r_shift);
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_dataRd = rd_en && (rd_addr == PS2_DATA_OFF);
  assign w_statRd = rd_en && (rd_addr == PS2_STAT_OFF);
  assign w_pop    = w_dataRd && !w_empty;
  assign w_ovfSet = r_push && w_full && !w_pop;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_data  (r_pushByte),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A STATUS read clears the sticky flags unless a new event lands in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_ovf  <= w_ovfSet  | (r_ovf  & ~w_statRd);
      r_perr <= r_perrSet | (r_perr & ~w_statRd);
    end
  end

  always_comb begin
    w_status                      = '0;
    w_status[ST_READY]            = !w_empty;
    w_status[ST_OVF]              = r_ovf;
    w_status[ST_PERR]             = r_perr;
    w_status[ST_CNT_LSB +: 4]     = 4'(w_count);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      keymemout <= '0;
    end else if (w_dataRd) begin
      keymemout <= w_empty ? 32'd0 : {24'd0, w_head};
    end else if (w_statRd) begin
      keymemout <= w_status;
    end else if (rd_en) begin
      keymemout <= '0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of single-frame cases plus hand-written
// sequences for overflow, simultaneous push/pop, timeout and mid-frame reset.
module tb_ps2_keyboard;

  localparam int HALF = 20;
  localparam int GAP  = 60;

  logic        clock    = 1'b0;
  logic        reset    = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en    = 1'b0;
  logic [3:0]  rd_addr  = 4'h0;
  logic [31:0] keymemout;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [7:0]  dataByte;
    logic        badParity;
    logic        stopBit;
    logic [31:0] expStat1;
    logic [31:0] expData;
    logic [31:0] expStat2;
  } frameVec_t;

  frameVec_t vecs [5];

  ps2_keyboard #(
    .FIFO_DEPTH (8),
    .TIMEOUT    (200)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .keymemout (keymemout)
  );

  always #10 clock = ~clock;

  initial begin
    repeat (90000) @(posedge clock);
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One PS/2 bit: data set while the line clock is high, then a full low/high clock period.
  task automatic ps2Bit(input logic b);
    @(negedge clock);
    ps2_data = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] dataByte, input logic badParity, input logic stopBit);
    logic par;
    par = (~(^dataByte)) ^ badParity;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(dataByte[i]);
    ps2Bit(par);
    ps2Bit(stopBit);
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] value);
    @(negedge clock);
    rd_en   = 1'b1;
    rd_addr = addr;
    @(negedge clock);
    rd_en   = 1'b0;
    value   = keymemout;
  endtask

  initial begin
    logic [31:0] rv;
    logic [7:0]  lastByte;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 32'h11, 32'h1C, 32'h00};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 32'h04, 32'h00, 32'h00};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, 32'h11, 32'hF0, 32'h00};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 32'h04, 32'h00, 32'h00};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 32'h11, 32'hFF, 32'h00};

    $display("[TB] reset state");
    repeat (3) @(negedge clock);
    checkOutput("keymemout in reset", keymemout, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    readReg(4'h4, rv);
    checkOutput("status after reset", rv, 32'h0);
    readReg(4'h0, rv);
    checkOutput("data when empty", rv, 32'h0);

    $display("[TB] single-frame table");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].dataByte, vecs[v].badParity, vecs[v].stopBit);
      readReg(4'h4, rv);
      checkOutput($sformatf("vec%0d status before", v), rv, vecs[v].expStat1);
      readReg(4'h0, rv);
      checkOutput($sformatf("vec%0d data", v), rv, vecs[v].expData);
      repeat (3) @(negedge clock);
      checkOutput($sformatf("vec%0d hold", v), keymemout, vecs[v].expData);
      readReg(4'h4, rv);
      checkOutput($sformatf("vec%0d status after", v), rv, vecs[v].expStat2);
    end

    $display("[TB] overflow with nine frames");
    for (int f = 1; f <= 9; f++) applyStimulus(8'(f), 1'b0, 1'b1);
    readReg(4'h4, rv);
    checkOutput("overflow status", rv, 32'h83);
    readReg(4'h8, rv);
    checkOutput("unmapped offset", rv, 32'h0);
    for (int f = 1; f <= 8; f++) begin
      readReg(4'h0, rv);
      checkOutput($sformatf("overflow data %0d", f), rv, 32'(f));
    end
    readReg(4'h4, rv);
    checkOutput("status after drain", rv, 32'h0);

    $display("[TB] push and pop in the same cycle while full");
    for (int f = 0; f < 8; f++) applyStimulus(8'h10 + 8'(f), 1'b0, 1'b1);
    lastByte = 8'h18;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(lastByte[i]);
    ps2Bit(~(^lastByte));
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clock);
    rd_en   = 1'b1;
    rd_addr = 4'h0;
    @(negedge clock);
    rd_en = 1'b0;
    checkOutput("same-cycle pop data", keymemout, 32'h10);
    repeat (HALF - 5) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clock);
    readReg(4'h4, rv);
    checkOutput("same-cycle status", rv, 32'h81);
    for (int f = 1; f <= 8; f++) begin
      readReg(4'h0, rv);
      checkOutput($sformatf("same-cycle data %0d", f), rv, 32'h10 + 32'(f));
    end
    readReg(4'h4, rv);
    checkOutput("same-cycle status drained", rv, 32'h0);

    $display("[TB] partial frame timeout");
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b1);
    repeat (300) @(negedge clock);
    applyStimulus(8'h5A, 1'b0, 1'b1);
    readReg(4'h4, rv);
    checkOutput("timeout status", rv, 32'h11);
    readReg(4'h0, rv);
    checkOutput("timeout data", rv, 32'h5A);
    readReg(4'h4, rv);
    checkOutput("timeout status after", rv, 32'h0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h33, 1'b0, 1'b1);
    readReg(4'h4, rv);
    checkOutput("pre-reset status", rv, 32'h11);
    ps2Bit(1'b0);
    ps2Bit(1'b1);
    ps2Bit(1'b0);
    ps2Bit(1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("keymemout during reset", keymemout, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) ps2Bit(1'b1);
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clock);
    applyStimulus(8'h29, 1'b0, 1'b1);
    readReg(4'h4, rv);
    checkOutput("post-reset status", rv, 32'h11);
    readReg(4'h0, rv);
    checkOutput("post-reset data", rv, 32'h29);
    readReg(4'h4, rv);
    checkOutput("post-reset status after", rv, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
